// File: rtl/order_pack_4.sv
// Packs a serial word stream into 4-word groups for the 4-input sorter, double-buffered.
// Define ORDER_PACK_LAST_EN to let in_last close partial groups (PAD-filled).
module order_pack_4 #(
  parameter int unsigned      DSIZE = 8,
  parameter logic [DSIZE-1:0] PAD   = '0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data0,
  output logic [DSIZE-1:0] out_data1,
  output logic [DSIZE-1:0] out_data2,
  output logic [DSIZE-1:0] out_data3,
  output logic [2:0]       out_cnt,
  output logic             out_last,
  output logic             dbg_state
);

  // Handshake: a word moves when in_valid && in_ready, a group when out_valid && out_ready.
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [1:0]       wp_q, wp_d;
  logic [DSIZE-1:0] fill_q [4];
  logic [DSIZE-1:0] fill_d [4];
  logic [DSIZE-1:0] grp [4];
  logic [2:0]       fill_cnt_q, fill_cnt_d;
  logic             fill_last_q, fill_last_d;
  logic             out_valid_q, out_valid_d;
  logic [DSIZE-1:0] out_q [4];
  logic [DSIZE-1:0] out_d [4];
  logic [2:0]       out_cnt_q, out_cnt_d;
  logic             out_last_q, out_last_d;
  logic             word_last, accept, close, out_xfer, out_free;

`ifdef ORDER_PACK_LAST_EN
  assign word_last = in_last;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign word_last      = 1'b0;
`endif

  always_comb begin
    in_ready = (state_q == FILL);
    accept   = in_valid && in_ready;
    out_xfer = out_valid_q && out_ready;
    out_free = !out_valid_q || out_ready;
    close    = accept && ((wp_q == 2'd3) || word_last);
    // Group as it would look if closed by the current word: later slots padded.
    for (int i = 0; i < 4; i++) begin
      if (2'(i) < wp_q)       grp[i] = fill_q[i];
      else if (2'(i) == wp_q) grp[i] = in_data;
      else                    grp[i] = PAD;
    end

    state_d     = state_q;
    wp_d        = wp_q;
    fill_d      = fill_q;
    fill_cnt_d  = fill_cnt_q;
    fill_last_d = fill_last_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_cnt_d   = out_cnt_q;
    out_last_d  = out_last_q;

    if (out_xfer) begin
      out_valid_d = 1'b0;
      out_cnt_d   = 3'd0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      FILL: begin
        if (close) begin
          wp_d = 2'd0;
          if (out_free) begin
            out_d       = grp;
            out_valid_d = 1'b1;
            out_cnt_d   = {1'b0, wp_q} + 3'd1;
            out_last_d  = word_last;
          end else begin
            fill_d      = grp;
            fill_cnt_d  = {1'b0, wp_q} + 3'd1;
            fill_last_d = word_last;
            state_d     = HOLD;
          end
        end else if (accept) begin
          fill_d[wp_q] = in_data;
          wp_d         = wp_q + 2'd1;
        end
      end
      HOLD: begin
        if (out_xfer) begin
          out_d       = fill_q;
          out_valid_d = 1'b1;
          out_cnt_d   = fill_cnt_q;
          out_last_d  = fill_last_q;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wp_q        <= 2'd0;
      fill_cnt_q  <= 3'd0;
      fill_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_cnt_q   <= 3'd0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        fill_q[i] <= PAD;
        out_q[i]  <= PAD;
      end
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_last_q <= fill_last_d;
      out_valid_q <= out_valid_d;
      out_cnt_q   <= out_cnt_d;
      out_last_q  <= out_last_d;
      fill_q      <= fill_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data0 = out_q[0];
  assign out_data1 = out_q[1];
  assign out_data2 = out_q[2];
  assign out_data3 = out_q[3];
  assign out_cnt   = out_cnt_q;
  assign out_last  = out_last_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_order_pack_4.sv
// Bench for order_pack_4: vector table, hand sequences, and random traffic against a group-queue model.
module tb_order_pack_4;
  localparam int GW = 36;
  localparam logic [7:0] PADV = 8'd0;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_last, out_valid, out_ready, out_last, dbg_state;
  logic [7:0] in_data, out_data0, out_data1, out_data2, out_data3;
  logic [2:0] out_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]    cur_q[$];
  logic [GW-1:0] exp_q[$];

  typedef struct {
    logic          iv;
    logic [7:0]    d;
    logic          l;
    logic          ordy;
    logic          exp_ov;
    logic          exp_ir;
    logic [GW-1:0] exp_g;
  } vec_t;
  vec_t tbl[$];

  order_pack_4 #(.DSIZE(8), .PAD(PADV)) dut (
    .clock(clock), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .out_cnt(out_cnt), .out_last(out_last), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [GW-1:0] pk(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d,
                                       input logic [2:0] cnt, input logic last);
    return {a, b, c, d, cnt, last};
  endfunction

  function automatic logic [GW-1:0] dut_grp();
    return {out_data0, out_data1, out_data2, out_data3, out_cnt, out_last};
  endfunction

  task automatic chk(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words collect into the current group; a closed group joins the pending queue.
  task automatic model_accept(input logic [7:0] d, input logic l);
    logic [7:0] s [4];
    logic       closes;
    cur_q.push_back(d);
`ifdef ORDER_PACK_LAST_EN
    closes = (cur_q.size() == 4) || l;
`else
    closes = (cur_q.size() == 4);
    l = 1'b0;
`endif
    if (closes) begin
      for (int i = 0; i < 4; i++) s[i] = (i < cur_q.size()) ? cur_q[i] : PADV;
      exp_q.push_back(pk(s[0], s[1], s[2], s[3], 3'(cur_q.size()), l));
      cur_q.delete();
    end
  endtask

  // Entered at posedge+1; drives inputs, samples handshakes before the edge, checks after it.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic l, input logic ordy);
    logic acc, xfer;
    in_valid = iv; in_data = d; in_last = l; out_ready = ordy;
    #1;
    acc  = in_valid && in_ready;
    xfer = out_valid && out_ready;
    @(posedge clock);
    #1;
    if (xfer && exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) model_accept(d, l);
    chk("out_valid", {35'd0, out_valid}, {35'd0, exp_q.size() != 0});
    chk("in_ready", {35'd0, in_ready}, {35'd0, exp_q.size() < 2});
    if (out_valid && exp_q.size() > 0) chk("group", dut_grp(), exp_q[0]);
`ifndef ORDER_PACK_LAST_EN
    if (!out_valid) chk("idle_cnt_last", {32'd0, out_cnt, out_last}, 36'd0);
`endif
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {35'd0, out_valid}, 36'd0);
    chk("rst_in_ready", {35'd0, in_ready}, 36'd1);
    chk("rst_outputs", dut_grp(), pk(PADV, PADV, PADV, PADV, 3'd0, 1'b0));
    chk("rst_state", {35'd0, dbg_state}, 36'd0);
    exp_q.delete();
    cur_q.delete();
    @(posedge clock); #1;
    @(posedge clock); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // 5,9,2,7 with out_ready high
    tbl.push_back('{1'b1, 8'd5, 1'b0, 1'b1, 1'b0, 1'b1, 36'd0});
    tbl.push_back('{1'b1, 8'd9, 1'b0, 1'b1, 1'b0, 1'b1, 36'd0});
    tbl.push_back('{1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 1'b1, 36'd0});
    tbl.push_back('{1'b1, 8'd7, 1'b0, 1'b1, 1'b1, 1'b1, pk(8'd5, 8'd9, 8'd2, 8'd7, 3'd4, 1'b0)});
    tbl.push_back('{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 36'd0});
    // 1..8 streaming, no stall
    for (int w = 1; w <= 8; w++)
      tbl.push_back('{1'b1, 8'(w), 1'b0, 1'b1, (w == 4 || w == 8), 1'b1,
                      (w == 4) ? pk(8'd1, 8'd2, 8'd3, 8'd4, 3'd4, 1'b0)
                               : pk(8'd5, 8'd6, 8'd7, 8'd8, 3'd4, 1'b0)});
    tbl.push_back('{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 36'd0});
    // 1..8 under backpressure, then release
    for (int w = 1; w <= 8; w++)
      tbl.push_back('{1'b1, 8'(w), 1'b0, 1'b0, (w >= 4), (w != 8),
                      pk(8'd1, 8'd2, 8'd3, 8'd4, 3'd4, 1'b0)});
    tbl.push_back('{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, pk(8'd5, 8'd6, 8'd7, 8'd8, 3'd4, 1'b0)});
    tbl.push_back('{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 36'd0});

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].iv, tbl[i].d, tbl[i].l, tbl[i].ordy);
      chk("tbl_out_valid", {35'd0, out_valid}, {35'd0, tbl[i].exp_ov});
      chk("tbl_in_ready", {35'd0, in_ready}, {35'd0, tbl[i].exp_ir});
      if (tbl[i].exp_ov) chk("tbl_group", dut_grp(), tbl[i].exp_g);
    end

    // in_last closing a partial group
    cycle(1'b1, 8'd3, 1'b0, 1'b1);
    cycle(1'b1, 8'd6, 1'b1, 1'b1);
`ifdef ORDER_PACK_LAST_EN
    chk("last_valid", {35'd0, out_valid}, 36'd1);
    chk("last_group", dut_grp(), pk(8'd3, 8'd6, PADV, PADV, 3'd2, 1'b1));
    for (int w = 1; w <= 4; w++) cycle(1'b1, 8'(w), 1'b0, 1'b1);
    chk("after_last_group", dut_grp(), pk(8'd1, 8'd2, 8'd3, 8'd4, 3'd4, 1'b0));
`else
    chk("nolast_valid", {35'd0, out_valid}, 36'd0);
    cycle(1'b1, 8'd1, 1'b0, 1'b1);
    cycle(1'b1, 8'd2, 1'b0, 1'b1);
    chk("nolast_group", dut_grp(), pk(8'd3, 8'd6, 8'd1, 8'd2, 3'd4, 1'b0));
`endif
    cycle(1'b0, 8'd0, 1'b0, 1'b1);

    // reset mid-group, then a fresh group
    cycle(1'b1, 8'd5, 1'b0, 1'b1);
    cycle(1'b1, 8'd9, 1'b0, 1'b1);
    do_reset();
    for (int w = 10; w <= 13; w++) cycle(1'b1, 8'(w), 1'b0, 1'b1);
    chk("fresh_group", dut_grp(), pk(8'd10, 8'd11, 8'd12, 8'd13, 3'd4, 1'b0));

    // reset while a group is held
    for (int w = 1; w <= 8; w++) cycle(1'b1, 8'(w + 20), 1'b0, 1'b0);
    chk("held_in_ready", {35'd0, in_ready}, 36'd0);
    do_reset();
    for (int w = 40; w <= 43; w++) cycle(1'b1, 8'(w), 1'b0, 1'b1);
    chk("fresh_group2", dut_grp(), pk(8'd40, 8'd41, 8'd42, 8'd43, 3'd4, 1'b0));

    // random traffic
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'd0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
